mc_ctrl_fsm: RTL and testbench

Main control FSM for the multicycle RV32I core. It is the next generation of the existing control FSM. It adds JALR, LUI and AUIPC sequences and a memory request/ready handshake with wait states. It also adds a programmable memory-wait timeout, an illegal-opcode trap state and an instruction-retire pulse. It sits between the instruction register's opcode field and the datapath muxes and enables; the ALU decoder consumes ALUOp.

---
 rtl/mc_ctrl_pkg.sv | 64 ++++++
 rtl/mc_ctrl_fsm_wait_timer.sv | 32 +++
 rtl/mc_ctrl_fsm.sv | 189 ++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control FSM.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_JAL      = 4'd8,
    S_JALR_ADR = 4'd9,
    S_LUI      = 4'd10,
    S_AUIPC    = 4'd11,
    S_ALUWB    = 4'd12,
    S_BRANCH   = 4'd13,
    S_TRAP     = 4'd14
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_BR   = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  // Opcode dispatch out of DECODE; unknown opcodes trap.
  function automatic state_t decode_op(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_STORE: decode_op = S_MEMADR;
      OP_RTYPE:          decode_op = S_EXECR;
      OP_ITYPE:          decode_op = S_EXECI;
      OP_JAL:            decode_op = S_JAL;
      OP_JALR:           decode_op = S_JALR_ADR;
      OP_LUI:            decode_op = S_LUI;
      OP_AUIPC:          decode_op = S_AUIPC;
      OP_BRANCH:         decode_op = S_BRANCH;
      default:           decode_op = S_TRAP;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_wait_timer.sv
// Consecutive memory wait-cycle counter with an optional expiry limit.
module mc_wait_timer #(
  parameter int TO_W        = 8,
  parameter int MEM_TIMEOUT = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic wait_cyc,
  output logic expired
);

  localparam logic [TO_W-1:0] LIMIT   = TO_W'(MEM_TIMEOUT);
  localparam bit              ENABLED = (MEM_TIMEOUT != 0);

  logic [TO_W-1:0] count;

  // Expiry is only possible on a wait cycle, so a ready cycle always wins.
  assign expired = ENABLED && wait_cyc && (count == LIMIT);

  // Count consecutive waits; any non-wait cycle or an expiry restarts at zero,
  // which also clears the count on entry to every memory state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (wait_cyc && !expired) begin
      if (count != '1) count <= count + 1'b1;
    end else begin
      count <= '0;
    end
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Main control FSM of the multicycle RV32I core: Moore-decoded datapath
// controls, memory request/ready handshake with wait timeout, trap state.
//
// Memory handshake: MemReq is high for the whole of FETCH, MEMREAD and
// MEMWRITE. A request completes in the cycle mem_ready is sampled high while
// MemReq is high; each cycle with MemReq high and mem_ready low is a wait
// cycle and the FSM holds. With MEM_HANDSHAKE=0, mem_ready reads as 1.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_HANDSHAKE = 1,
  parameter int MEM_TIMEOUT   = 0,
  parameter int TO_W          = 8,
  parameter int TRAP_STICKY   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       mem_ready,
  output logic       Branch,
  output logic       PCUpdate,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemReq,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       AdrSrc,
  output logic [1:0] ALUOp,
  output logic       illegal,
  output logic       bus_err,
  output logic       retire,
  output logic [3:0] state_dbg
);

  state_t state, state_nxt;
  logic   ready_eff;
  logic   in_mem_state;
  logic   wait_cyc;
  logic   expired;

  assign ready_eff    = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
  assign in_mem_state = (state == S_FETCH) || (state == S_MEMREAD) ||
                        (state == S_MEMWRITE);
  assign wait_cyc     = in_mem_state && !ready_eff;
  assign state_dbg    = state;

  mc_wait_timer #(
    .TO_W        (TO_W),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk      (clk),
    .reset    (reset),
    .wait_cyc (wait_cyc),
    .expired  (expired)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  // Next-state: memory states hold on wait and trap on timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:    if (expired) state_nxt = S_TRAP;
                  else if (ready_eff) state_nxt = S_DECODE;
      S_DECODE:   state_nxt = decode_op(op);
      S_MEMADR:   state_nxt = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (expired) state_nxt = S_TRAP;
                  else if (ready_eff) state_nxt = S_MEMWB;
      S_MEMWB:    state_nxt = S_FETCH;
      S_MEMWRITE: if (expired) state_nxt = S_TRAP;
                  else if (ready_eff) state_nxt = S_FETCH;
      S_EXECR:    state_nxt = S_ALUWB;
      S_EXECI:    state_nxt = S_ALUWB;
      S_JALR_ADR: state_nxt = S_JAL;
      S_JAL:      state_nxt = S_ALUWB;
      S_AUIPC:    state_nxt = S_ALUWB;
      S_LUI:      state_nxt = S_FETCH;
      S_ALUWB:    state_nxt = S_FETCH;
      S_BRANCH:   state_nxt = S_FETCH;
      S_TRAP:     state_nxt = (TRAP_STICKY != 0) ? S_TRAP : S_FETCH;
      default:    state_nxt = S_FETCH;
    endcase
  end

  // Outputs: Moore decode, ready gating in memory states, reset override.
  always_comb begin
    Branch    = 1'b0;
    PCUpdate  = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    MemReq    = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RD2;
    AdrSrc    = 1'b0;
    ALUOp     = ALUOP_ADD;
    illegal   = 1'b0;
    bus_err   = expired;
    retire    = 1'b0;
    case (state)
      S_FETCH: begin
        MemReq    = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
        IRWrite   = ready_eff;
        PCUpdate  = ready_eff;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
        retire    = 1'b1;
      end
      S_MEMWRITE: begin
        MemReq   = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = !expired;
        retire   = ready_eff;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_RD2;
        ALUOp   = ALUOP_FUNC;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_FUNC;
      end
      S_JALR_ADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
      end
      S_JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALUOUT;
        PCUpdate  = 1'b1;
      end
      S_LUI: begin
        ResultSrc = RES_IMM;
        RegWrite  = 1'b1;
        retire    = 1'b1;
      end
      S_ALUWB: begin
        ResultSrc = RES_ALUOUT;
        RegWrite  = 1'b1;
        retire    = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_RD2;
        ALUOp   = ALUOP_BR;
        Branch  = 1'b1;
        retire  = 1'b1;
      end
      S_TRAP: illegal = 1'b1;
      default: ;
    endcase
    if (reset) begin
      PCUpdate = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      MemReq   = 1'b0;
      retire   = 1'b0;
      bus_err  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: three instances with different parameters share
// op/mem_ready; each has its own reset. Cycle vectors hold hand-written
// expected state and control words.
module tb_mc_ctrl_fsm;
  import mc_ctrl_pkg::*;

  // clock / reset
  logic       clk = 1'b0;
  logic [2:0] rst_v;
  logic [6:0] op;
  logic       mem_ready;
  always #5 clk = ~clk;

  logic       o_br [3], o_pcu [3], o_rw [3], o_mw [3], o_irw [3], o_mr [3];
  logic       o_adr [3], o_ill [3], o_be [3], o_ret [3];
  logic [1:0] o_res [3], o_asrc [3], o_bsrc [3], o_aluop [3];
  logic [3:0] o_st [3];

  // dut 0: handshake, timeout 8, sticky; dut 1: timeout 5, sticky;
  // dut 2: no handshake, no timeout, non-sticky trap
  for (genvar g = 0; g < 3; g++) begin : g_dut
    mc_ctrl_fsm #(
      .MEM_HANDSHAKE (g == 2 ? 0 : 1),
      .MEM_TIMEOUT   (g == 0 ? 8 : (g == 1 ? 5 : 0)),
      .TO_W          (8),
      .TRAP_STICKY   (g == 2 ? 0 : 1)
    ) u_dut (
      .clk       (clk),
      .reset     (rst_v[g]),
      .op        (op),
      .mem_ready (mem_ready),
      .Branch    (o_br[g]),
      .PCUpdate  (o_pcu[g]),
      .RegWrite  (o_rw[g]),
      .MemWrite  (o_mw[g]),
      .IRWrite   (o_irw[g]),
      .MemReq    (o_mr[g]),
      .ResultSrc (o_res[g]),
      .ALUSrcA   (o_asrc[g]),
      .ALUSrcB   (o_bsrc[g]),
      .AdrSrc    (o_adr[g]),
      .ALUOp     (o_aluop[g]),
      .illegal   (o_ill[g]),
      .bus_err   (o_be[g]),
      .retire    (o_ret[g]),
      .state_dbg (o_st[g])
    );
  end

  // control word: {br,pcu,rw,mw,irw,mr,res,asrc,bsrc,adr,aluop,ill,be,ret}
  function automatic logic [17:0] pk(input logic br, pc, rw, mw, ir, mr,
                                     input logic [1:0] res, a, b,
                                     input logic adr, input logic [1:0] alu,
                                     input logic ill, be, ret);
    return {br, pc, rw, mw, ir, mr, res, a, b, adr, alu, ill, be, ret};
  endfunction

  function automatic logic [17:0] get_ctl(input int d);
    return {o_br[d], o_pcu[d], o_rw[d], o_mw[d], o_irw[d], o_mr[d], o_res[d],
            o_asrc[d], o_bsrc[d], o_adr[d], o_aluop[d], o_ill[d], o_be[d],
            o_ret[d]};
  endfunction

  logic [17:0] c_rst, c_fetch_r, c_fetch_w, c_fetch_x, c_dec, c_madr, c_mrd;
  logic [17:0] c_mwb, c_mwr_w, c_mwr_r, c_mwr_x, c_execr, c_execi, c_jalra;
  logic [17:0] c_jal, c_auipc, c_lui, c_alu_wb, c_br, c_trap;

  typedef struct {
    string       name;
    int          dut;
    logic        rst;
    logic [6:0]  op;
    logic        rdy;
    state_t      st;
    logic [17:0] ctl;
  } vec_t;
  vec_t vecs[$];

  // scoreboard
  logic [21:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic add(input string nm, input int d, input logic r,
                     input logic [6:0] o, input logic rd, input state_t s,
                     input logic [17:0] c);
    vec_t v;
    v.name = nm; v.dut = d; v.rst = r; v.op = o; v.rdy = rd; v.st = s;
    v.ctl = c;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input int d);
    logic [21:0] e;
    e = exp_q.pop_front();
    total++;
    if (o_st[d] !== e[21:18]) begin
      bad++;
      $display("FAIL %s dut%0d state: got %0d want %0d", nm, d, o_st[d],
               e[21:18]);
    end
    total++;
    if (get_ctl(d) !== e[17:0]) begin
      bad++;
      $display("FAIL %s dut%0d ctl: got %b want %b", nm, d, get_ctl(d),
               e[17:0]);
    end
  endtask

  initial begin
    rst_v     = 3'b111;
    op        = OP_RTYPE;
    mem_ready = 1'b1;

    c_rst     = pk(0,0,0,0,0,0, 2'b10,2'b00,2'b10, 0,2'b00, 0,0,0);
    c_fetch_r = pk(0,1,0,0,1,1, 2'b10,2'b00,2'b10, 0,2'b00, 0,0,0);
    c_fetch_w = pk(0,0,0,0,0,1, 2'b10,2'b00,2'b10, 0,2'b00, 0,0,0);
    c_fetch_x = pk(0,0,0,0,0,1, 2'b10,2'b00,2'b10, 0,2'b00, 0,1,0);
    c_dec     = pk(0,0,0,0,0,0, 2'b00,2'b01,2'b01, 0,2'b00, 0,0,0);
    c_madr    = pk(0,0,0,0,0,0, 2'b00,2'b10,2'b01, 0,2'b00, 0,0,0);
    c_mrd     = pk(0,0,0,0,0,1, 2'b00,2'b00,2'b00, 1,2'b00, 0,0,0);
    c_mwb     = pk(0,0,1,0,0,0, 2'b01,2'b00,2'b00, 0,2'b00, 0,0,1);
    c_mwr_w   = pk(0,0,0,1,0,1, 2'b00,2'b00,2'b00, 1,2'b00, 0,0,0);
    c_mwr_r   = pk(0,0,0,1,0,1, 2'b00,2'b00,2'b00, 1,2'b00, 0,0,1);
    c_mwr_x   = pk(0,0,0,0,0,1, 2'b00,2'b00,2'b00, 1,2'b00, 0,1,0);
    c_execr   = pk(0,0,0,0,0,0, 2'b00,2'b10,2'b00, 0,2'b10, 0,0,0);
    c_execi   = pk(0,0,0,0,0,0, 2'b00,2'b10,2'b01, 0,2'b10, 0,0,0);
    c_jalra   = pk(0,0,0,0,0,0, 2'b00,2'b10,2'b01, 0,2'b00, 0,0,0);
    c_jal     = pk(0,1,0,0,0,0, 2'b00,2'b01,2'b10, 0,2'b00, 0,0,0);
    c_auipc   = pk(0,0,0,0,0,0, 2'b00,2'b00,2'b00, 0,2'b00, 0,0,0);
    c_lui     = pk(0,0,1,0,0,0, 2'b11,2'b00,2'b00, 0,2'b00, 0,0,1);
    c_alu_wb  = pk(0,0,1,0,0,0, 2'b00,2'b00,2'b00, 0,2'b00, 0,0,1);
    c_br      = pk(1,0,0,0,0,0, 2'b00,2'b10,2'b00, 0,2'b01, 0,0,1);
    c_trap    = pk(0,0,0,0,0,0, 2'b00,2'b00,2'b00, 0,2'b00, 1,0,0);

    // dut 0: add, lw with 3 waits, sw, jalr, lui, auipc, addi, beq, fetch wait
    add("rst",     0, 1, OP_RTYPE, 1, S_FETCH,    c_rst);
    add("add_f",   0, 0, OP_RTYPE, 1, S_FETCH,    c_fetch_r);
    add("add_d",   0, 0, OP_RTYPE, 1, S_DECODE,   c_dec);
    add("add_x",   0, 0, OP_RTYPE, 1, S_EXECR,    c_execr);
    add("add_wb",  0, 0, OP_RTYPE, 1, S_ALUWB,    c_alu_wb);
    add("lw_f",    0, 0, OP_LOAD,  1, S_FETCH,    c_fetch_r);
    add("lw_d",    0, 0, OP_LOAD,  1, S_DECODE,   c_dec);
    add("lw_a",    0, 0, OP_LOAD,  1, S_MEMADR,   c_madr);
    for (int i = 0; i < 3; i++)
      add("lw_wait", 0, 0, OP_LOAD, 0, S_MEMREAD, c_mrd);
    add("lw_rd",   0, 0, OP_LOAD,  1, S_MEMREAD,  c_mrd);
    add("lw_wb",   0, 0, OP_LOAD,  1, S_MEMWB,    c_mwb);
    add("sw_f",    0, 0, OP_STORE, 1, S_FETCH,    c_fetch_r);
    add("sw_d",    0, 0, OP_STORE, 1, S_DECODE,   c_dec);
    add("sw_a",    0, 0, OP_STORE, 1, S_MEMADR,   c_madr);
    add("sw_w",    0, 0, OP_STORE, 1, S_MEMWRITE, c_mwr_r);
    add("jalr_f",  0, 0, OP_JALR,  1, S_FETCH,    c_fetch_r);
    add("jalr_d",  0, 0, OP_JALR,  1, S_DECODE,   c_dec);
    add("jalr_a",  0, 0, OP_JALR,  1, S_JALR_ADR, c_jalra);
    add("jalr_j",  0, 0, OP_JALR,  1, S_JAL,      c_jal);
    add("jalr_wb", 0, 0, OP_JALR,  1, S_ALUWB,    c_alu_wb);
    add("lui_f",   0, 0, OP_LUI,   1, S_FETCH,    c_fetch_r);
    add("lui_d",   0, 0, OP_LUI,   1, S_DECODE,   c_dec);
    add("lui_wb",  0, 0, OP_LUI,   1, S_LUI,      c_lui);
    add("aui_f",   0, 0, OP_AUIPC, 1, S_FETCH,    c_fetch_r);
    add("aui_d",   0, 0, OP_AUIPC, 1, S_DECODE,   c_dec);
    add("aui_x",   0, 0, OP_AUIPC, 1, S_AUIPC,    c_auipc);
    add("aui_wb",  0, 0, OP_AUIPC, 1, S_ALUWB,    c_alu_wb);
    add("addi_f",  0, 0, OP_ITYPE, 1, S_FETCH,    c_fetch_r);
    add("addi_d",  0, 0, OP_ITYPE, 1, S_DECODE,   c_dec);
    add("addi_x",  0, 0, OP_ITYPE, 1, S_EXECI,    c_execi);
    add("addi_wb", 0, 0, OP_ITYPE, 1, S_ALUWB,    c_alu_wb);
    add("jal_f",   0, 0, OP_JAL,   1, S_FETCH,    c_fetch_r);
    add("jal_d",   0, 0, OP_JAL,   1, S_DECODE,   c_dec);
    add("jal_j",   0, 0, OP_JAL,   1, S_JAL,      c_jal);
    add("jal_wb",  0, 0, OP_JAL,   1, S_ALUWB,    c_alu_wb);
    add("beq_f",   0, 0, OP_BRANCH,1, S_FETCH,    c_fetch_r);
    add("beq_d",   0, 0, OP_BRANCH,1, S_DECODE,   c_dec);
    add("beq_b",   0, 0, OP_BRANCH,1, S_BRANCH,   c_br);
    add("fw_wait", 0, 0, OP_RTYPE, 0, S_FETCH,    c_fetch_w);
    add("fw_rdy",  0, 0, OP_RTYPE, 1, S_FETCH,    c_fetch_r);
    add("fw_d",    0, 0, OP_RTYPE, 1, S_DECODE,   c_dec);

    // dut 1 (timeout 5): fetch timeout, ready at expiry, sw timeout
    add("rst1",    1, 1, OP_RTYPE, 0, S_FETCH,    c_rst);
    for (int i = 0; i < 5; i++)
      add("fto_wait", 1, 0, OP_RTYPE, 0, S_FETCH, c_fetch_w);
    add("fto_exp", 1, 0, OP_RTYPE, 0, S_FETCH,    c_fetch_x);
    add("fto_trap",1, 0, OP_RTYPE, 0, S_TRAP,     c_trap);
    add("rst1b",   1, 1, OP_LOAD,  1, S_FETCH,    c_rst);
    add("rw_f",    1, 0, OP_LOAD,  1, S_FETCH,    c_fetch_r);
    add("rw_d",    1, 0, OP_LOAD,  1, S_DECODE,   c_dec);
    add("rw_a",    1, 0, OP_LOAD,  1, S_MEMADR,   c_madr);
    for (int i = 0; i < 5; i++)
      add("rw_wait", 1, 0, OP_LOAD, 0, S_MEMREAD, c_mrd);
    add("rw_late", 1, 0, OP_LOAD,  1, S_MEMREAD,  c_mrd);
    add("rw_wb",   1, 0, OP_LOAD,  1, S_MEMWB,    c_mwb);
    add("rw_f2",   1, 0, OP_STORE, 1, S_FETCH,    c_fetch_r);
    add("sto_d",   1, 0, OP_STORE, 1, S_DECODE,   c_dec);
    add("sto_a",   1, 0, OP_STORE, 1, S_MEMADR,   c_madr);
    for (int i = 0; i < 5; i++)
      add("sto_wait", 1, 0, OP_STORE, 0, S_MEMWRITE, c_mwr_w);
    add("sto_exp", 1, 0, OP_STORE, 0, S_MEMWRITE, c_mwr_x);
    for (int i = 0; i < 20; i++)
      add("sto_trap", 1, 0, OP_STORE, i[0], S_TRAP, c_trap);

    // dut 2 (no handshake, non-sticky): illegal op, lw and sw ignore ready
    add("rst2",    2, 1, 7'h7f,    0, S_FETCH,    c_rst);
    add("ill_f",   2, 0, 7'h7f,    0, S_FETCH,    c_fetch_r);
    add("ill_d",   2, 0, 7'h7f,    0, S_DECODE,   c_dec);
    add("ill_t",   2, 0, 7'h7f,    0, S_TRAP,     c_trap);
    add("nh_lw_f", 2, 0, OP_LOAD,  0, S_FETCH,    c_fetch_r);
    add("nh_lw_d", 2, 0, OP_LOAD,  0, S_DECODE,   c_dec);
    add("nh_lw_a", 2, 0, OP_LOAD,  0, S_MEMADR,   c_madr);
    add("nh_lw_r", 2, 0, OP_LOAD,  0, S_MEMREAD,  c_mrd);
    add("nh_lw_wb",2, 0, OP_LOAD,  0, S_MEMWB,    c_mwb);
    add("nh_sw_f", 2, 0, OP_STORE, 0, S_FETCH,    c_fetch_r);
    add("nh_sw_d", 2, 0, OP_STORE, 0, S_DECODE,   c_dec);
    add("nh_sw_a", 2, 0, OP_STORE, 0, S_MEMADR,   c_madr);
    add("nh_sw_w", 2, 0, OP_STORE, 0, S_MEMWRITE, c_mwr_r);
    add("nh_f",    2, 0, OP_STORE, 0, S_FETCH,    c_fetch_r);

    repeat (2) @(negedge clk);
    rst_v = 3'b000;

    // driver: inputs on the falling edge, sample 1 time unit later
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      op                 = vecs[i].op;
      mem_ready          = vecs[i].rdy;
      rst_v[vecs[i].dut] = vecs[i].rst;
      exp_q.push_back({vecs[i].st, vecs[i].ctl});
      #1;
      check(vecs[i].name, vecs[i].dut);
    end

    // reset asserted asynchronously in the middle of a waiting MEMWRITE
    @(negedge clk);
    rst_v[0] = 1'b1; op = OP_STORE; mem_ready = 1'b1;
    @(negedge clk);
    rst_v[0] = 1'b0;
    @(negedge clk);                      // DECODE
    @(negedge clk);                      // MEMADR
    @(negedge clk);                      // MEMWRITE
    mem_ready = 1'b0;
    exp_q.push_back({S_MEMWRITE, c_mwr_w});
    #1 check("mid_sw_wait", 0);
    @(negedge clk);
    #3 rst_v[0] = 1'b1;
    exp_q.push_back({S_FETCH, c_rst});
    #1 check("mid_sw_rst", 0);
    @(negedge clk);
    rst_v[0] = 1'b0; mem_ready = 1'b1;
    exp_q.push_back({S_FETCH, c_fetch_r});
    #1 check("post_rst", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
